mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_array.sv | 34 +++
 rtl/mem_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the wait-state memory responder: FSM encodings,
// default geometry and the wait-state counter sizing.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = $clog2(WAIT_MAX + 1);

  // Encoding 2'd3 is unused; the FSM maps it back to ST_IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, registered read.
// Only the read register is reset; the array itself keeps its contents.
module mem_array
  import mem_pkg::*;
#(
  parameter int    DATA_W    = DATA_W_DEF,
  parameter int    DEPTH     = DEPTH_DEF,
  parameter string INIT_FILE = "",
  localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: captures one request in IDLE, waits WAIT_CYCLES
// edges, then pulses ack for one cycle with read data or an address error.
module mem_responder
  import mem_pkg::*;
#(
  parameter int    DATA_W      = DATA_W_DEF,
  parameter int    DEPTH       = DEPTH_DEF,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [1:0]        state,
  output logic [15:0]       txn_count
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0]      DEPTH_L = 17'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [15:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rd_err_q, rd_err_d;
  logic [15:0]       txn_q, txn_d;

  logic              enter_resp;
  logic              acc_we;
  logic [15:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_valid;
  logic              mem_en;
  logic [DATA_W-1:0] arr_rdata;

  // With zero wait states the access completes on the capture edge, so the
  // array must see the live request rather than the captured copy.
  always_comb begin
    acc_we    = (state_q == ST_IDLE) ? we    : we_q;
    acc_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
    acc_valid = {1'b0, acc_addr} < DEPTH_L;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_L;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // rdata only changes on read completions; an errored read forces it to 0.
  always_comb begin
    mem_en   = enter_resp && acc_valid;
    err_d    = enter_resp && !acc_valid;
    rd_err_d = rd_err_q;
    if (enter_resp && !acc_we) rd_err_d = !acc_valid;
    txn_d = enter_resp ? txn_q + 16'd1 : txn_q;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rd_err_q <= 1'b0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rd_err_q <= rd_err_d;
      txn_q    <= txn_d;
    end
  end

  mem_array #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_mem_array (
    .clk_i  (CLK),
    .rst_ni (reset),
    .en_i   (mem_en),
    .we_i   (acc_we),
    .addr_i (acc_addr[AW-1:0]),
    .wdata_i(acc_wdata),
    .rdata_o(arr_rdata)
  );

  assign ack       = (state_q == ST_RESP);
  assign busy      = (state_q == ST_WAIT) || (state_q == ST_RESP);
  assign err       = err_q;
  assign rdata     = rd_err_q ? '0 : arr_rdata;
  assign state     = state_q;
  assign txn_count = txn_q;

endmodule
